// File: rtl/camera_pattern_gen.sv
// -----------------------------------------------------------------------------
// camera_pattern_gen
//
// Emulates a parallel CMOS camera sensor. A free-running pixel clock is
// derived from Clk, and frames of LINE_VALID / FRAME_VALID qualified test
// pattern data are produced on request. All qualifiers and data change only
// on the Clk edge where PIXEL_CLK falls, so a receiver sampling on the
// PIXEL_CLK rising edge always sees stable values.
//
// Ports:
//   Clk          in   1   single clock
//   Reset        in   1   synchronous, active-high reset
//   Enable       in   1   request frame generation (sampled on fall ticks)
//   PIXEL_CLK    out  1   emulated sensor pixel clock (Clk / CLK_DIV)
//   LINE_VALID   out  1   line qualifier
//   FRAME_VALID  out  1   frame qualifier
//   PIXEL_DATA   out  10  pixel value, (x + y + frame_cnt) mod 1024
//   frame_done   out  1   one-Clk pulse when a frame (incl. VBLANK) ends
//   busy         out  1   high while a frame is in progress
//
// Build option:
//   CAM_FRAME_STAMP_EN  when defined, pixel (0,0) of each frame carries the
//                       frame counter instead of the test pattern.
//
// V_PRE, V_POST and V_BLANK are expected to be at least 1; H_BLANK may be 0.
// -----------------------------------------------------------------------------
module camera_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_PRE    = 2,
    parameter int V_POST   = 2,
    parameter int V_BLANK  = 8,
    parameter int CLK_DIV  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    output logic       PIXEL_CLK,
    output logic       LINE_VALID,
    output logic       FRAME_VALID,
    output logic [9:0] PIXEL_DATA,
    output logic       frame_done,
    output logic       busy
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACTIVE,
        HBLANK,
        POST,
        VBLANK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [CW-1:0] div_q, div_d;
    logic [9:0]    frameCnt_q, frameCnt_d;
    logic          pixClk_q, pixClk_d;
    logic          lv_q, lv_d;
    logic          fv_q, fv_d;
    logic [9:0]    data_q, data_d;
    logic          frameDone_q, frameDone_d;
    logic          busy_q, busy_d;
    logic          divWrap;
    logic          fallTick;

    // Pixel clock divider: each half period lasts HALF Clk cycles. The fall
    // tick is the Clk edge on which PIXEL_CLK goes from 1 to 0; all state and
    // output updates are gated by it.
    always_comb begin
        divWrap  = (div_q == CW'(HALF - 1));
        div_d    = divWrap ? '0 : div_q + CW'(1);
        pixClk_d = divWrap ? ~pixClk_q : pixClk_q;
        fallTick = divWrap && pixClk_q;
    end

    // Frame sequencer. Between fall ticks every next-state value equals the
    // current one, so the registers below can load unconditionally. cnt_q
    // times PRE/HBLANK/POST/VBLANK; x_q doubles as the ACTIVE period counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        frameCnt_d  = frameCnt_q;
        frameDone_d = 1'b0;

        if (fallTick) begin
            case (state_q)
                IDLE: begin
                    if (Enable) begin
                        state_d = PRE;
                        cnt_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
                PRE: begin
                    if (cnt_q == CW'(V_PRE - 1)) begin
                        state_d = ACTIVE;
                        x_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ACTIVE: begin
                    if (x_q == CW'(H_ACTIVE - 1)) begin
                        cnt_d = '0;
                        if (y_q == CW'(V_ACTIVE - 1)) begin
                            state_d = POST;
                        end else if (H_BLANK == 0) begin
                            x_d = '0;
                            y_d = y_q + CW'(1);
                        end else begin
                            state_d = HBLANK;
                        end
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
                HBLANK: begin
                    if (cnt_q == CW'(H_BLANK - 1)) begin
                        state_d = ACTIVE;
                        x_d     = '0;
                        y_d     = y_q + CW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                POST: begin
                    if (cnt_q == CW'(V_POST - 1)) begin
                        state_d = VBLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                VBLANK: begin
                    if (cnt_q == CW'(V_BLANK - 1)) begin
                        frameDone_d = 1'b1;
                        frameCnt_d  = frameCnt_q + 10'd1;
                        cnt_d       = '0;
                        x_d         = '0;
                        y_d         = '0;
                        state_d     = Enable ? PRE : IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output values derived from the state being entered, so they appear on
    // the same fall tick that moves the sequencer.
    always_comb begin
        lv_d   = (state_d == ACTIVE);
        fv_d   = (state_d == PRE) || (state_d == ACTIVE) ||
                 (state_d == HBLANK) || (state_d == POST);
        busy_d = (state_d != IDLE);
        data_d = '0;
        if (state_d == ACTIVE) begin
`ifdef CAM_FRAME_STAMP_EN
            if ((x_d == '0) && (y_d == '0)) begin
                data_d = frameCnt_q;
            end else begin
                data_d = x_d[9:0] + y_d[9:0] + frameCnt_q;
            end
`else
            data_d = x_d[9:0] + y_d[9:0] + frameCnt_q;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            div_q       <= '0;
            frameCnt_q  <= '0;
            pixClk_q    <= 1'b0;
            lv_q        <= 1'b0;
            fv_q        <= 1'b0;
            data_q      <= '0;
            frameDone_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            div_q       <= div_d;
            frameCnt_q  <= frameCnt_d;
            pixClk_q    <= pixClk_d;
            lv_q        <= lv_d;
            fv_q        <= fv_d;
            data_q      <= data_d;
            frameDone_q <= frameDone_d;
            busy_q      <= busy_d;
        end
    end

    assign PIXEL_CLK   = pixClk_q;
    assign LINE_VALID  = lv_q;
    assign FRAME_VALID = fv_q;
    assign PIXEL_DATA  = data_q;
    assign frame_done  = frameDone_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_camera_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_camera_pattern_gen
//
// Self-checking bench for camera_pattern_gen with a small frame geometry
// (4x3 active, 20 pixel periods / 40 Clk per frame). Expected pixel values
// are queued when a frame is started and popped at each PIXEL_CLK rising
// edge where LINE_VALID is high. Outputs are sampled on the Clk falling edge.
// -----------------------------------------------------------------------------
module tb_camera_pattern_gen;

    localparam int H_ACTIVE = 4;
    localparam int H_BLANK  = 2;
    localparam int V_ACTIVE = 3;
    localparam int V_PRE    = 1;
    localparam int V_POST   = 1;
    localparam int V_BLANK  = 2;
    localparam int CLK_DIV  = 2;

    logic       Clk;
    logic       Reset;
    logic       Enable;
    logic       PIXEL_CLK;
    logic       LINE_VALID;
    logic       FRAME_VALID;
    logic [9:0] PIXEL_DATA;
    logic       frame_done;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    logic [9:0] expQ[$];

    camera_pattern_gen #(
        .H_ACTIVE(H_ACTIVE),
        .H_BLANK (H_BLANK),
        .V_ACTIVE(V_ACTIVE),
        .V_PRE   (V_PRE),
        .V_POST  (V_POST),
        .V_BLANK (V_BLANK),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .PIXEL_CLK  (PIXEL_CLK),
        .LINE_VALID (LINE_VALID),
        .FRAME_VALID(FRAME_VALID),
        .PIXEL_DATA (PIXEL_DATA),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference pattern: (x + y + frame) mod 1024. Pixel (0,0) equals the
    // frame number under either build, so no build-specific model is needed.
    function automatic logic [9:0] expPix(input int x, input int y, input int f);
        int s;
        s = (x + y + f) % 1024;
        return s[9:0];
    endfunction

    // Queue one whole frame of expected active pixels.
    task automatic pushFrame(input int f);
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++)
                expQ.push_back(expPix(x, y, f));
    endtask

    // Hold reset for two Clk edges, then release on a falling edge.
    task automatic doReset(input logic en);
        @(negedge Clk);
        Reset  = 1'b1;
        Enable = en;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Reset values of every output.
    task automatic test_reset();
        @(negedge Clk);
        Reset  = 1'b1;
        Enable = 1'b1;
        @(negedge Clk);
        checks++; if (PIXEL_CLK !== 1'b0) begin fails++; $display("[TB] FAIL reset_pclk got %b exp 0", PIXEL_CLK); end
        checks++; if (LINE_VALID !== 1'b0) begin fails++; $display("[TB] FAIL reset_lv got %b exp 0", LINE_VALID); end
        checks++; if (FRAME_VALID !== 1'b0) begin fails++; $display("[TB] FAIL reset_fv got %b exp 0", FRAME_VALID); end
        checks++; if (PIXEL_DATA !== 10'd0) begin fails++; $display("[TB] FAIL reset_data got %0d exp 0", PIXEL_DATA); end
        checks++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_fd got %b exp 0", frame_done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        @(negedge Clk);
        checks++; if (PIXEL_CLK !== 1'b0) begin fails++; $display("[TB] FAIL reset_pclk_held got %b exp 0", PIXEL_CLK); end
        Reset  = 1'b0;
        Enable = 1'b0;
    endtask

    // Frame timing with Enable held high: FV rise, LV pulse train, VBLANK
    // length, frame_done position and back-to-back restart.
    task automatic test_frame_timing();
        int   cyc, fvRise, fdCyc, lvLen, gapLen, fvLow;
        logic prevLv;
        int   lens[$];
        int   gaps[$];
        doReset(1'b1);
        cyc = 0; fvRise = -1; fdCyc = -1; lvLen = 0; gapLen = 0; fvLow = 0; prevLv = 1'b0;
        while (fdCyc < 0 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            if (fvRise < 0 && FRAME_VALID === 1'b1) fvRise = cyc;
            if (fvRise >= 0 && cyc > fvRise && FRAME_VALID !== 1'b1 && frame_done !== 1'b1) fvLow++;
            if (LINE_VALID === 1'b1) begin
                if (!prevLv && lens.size() > 0) gaps.push_back(gapLen);
                lvLen++;
            end else begin
                if (prevLv) begin
                    lens.push_back(lvLen);
                    lvLen  = 0;
                    gapLen = 0;
                end
                gapLen++;
            end
            prevLv = LINE_VALID;
            if (frame_done === 1'b1) fdCyc = cyc;
        end
        checks++; if (fdCyc < 0) begin fails++; $display("[TB] FAIL timing_fd_timeout got none exp pulse within 200 Clk"); end
        checks++; if (fvRise !== 2) begin fails++; $display("[TB] FAIL timing_fv_rise got %0d exp 2", fvRise); end
        checks++; if (fdCyc - fvRise !== 40) begin fails++; $display("[TB] FAIL timing_frame_len got %0d exp 40", fdCyc - fvRise); end
        checks++; if (FRAME_VALID !== 1'b1) begin fails++; $display("[TB] FAIL timing_b2b_fv got %b exp 1", FRAME_VALID); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL timing_b2b_busy got %b exp 1", busy); end
        checks++; if (fvLow !== 2 * V_BLANK) begin fails++; $display("[TB] FAIL timing_vblank got %0d exp %0d", fvLow, 2 * V_BLANK); end
        checks++; if (lens.size() !== V_ACTIVE) begin fails++; $display("[TB] FAIL timing_lv_pulses got %0d exp %0d", lens.size(), V_ACTIVE); end
        foreach (lens[i]) begin
            checks++; if (lens[i] !== 2 * H_ACTIVE) begin fails++; $display("[TB] FAIL timing_lv_len[%0d] got %0d exp %0d", i, lens[i], 2 * H_ACTIVE); end
        end
        checks++; if (gaps.size() !== V_ACTIVE - 1) begin fails++; $display("[TB] FAIL timing_gaps got %0d exp %0d", gaps.size(), V_ACTIVE - 1); end
        foreach (gaps[i]) begin
            checks++; if (gaps[i] !== 2 * H_BLANK) begin fails++; $display("[TB] FAIL timing_gap_len[%0d] got %0d exp %0d", i, gaps[i], 2 * H_BLANK); end
        end
        @(negedge Clk);
        checks++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL timing_fd_width got %b exp 0", frame_done); end
    endtask

    // Pixel data for frames 0 and 1, zero data outside lines, and stability
    // of LV/FV/DATA across every PIXEL_CLK rising edge.
    task automatic test_pixel_data();
        int         cyc;
        logic       prevP, haveFall, fLv, fFv;
        logic [9:0] fData, e;
        doReset(1'b1);
        expQ.delete();
        pushFrame(0);
        pushFrame(1);
        cyc = 0; prevP = 1'b0; haveFall = 1'b0; fLv = 1'b0; fFv = 1'b0; fData = '0;
        while (expQ.size() > 0 && cyc < 300) begin
            @(negedge Clk);
            cyc++;
            if (prevP && !PIXEL_CLK) begin
                haveFall = 1'b1;
                fLv = LINE_VALID; fFv = FRAME_VALID; fData = PIXEL_DATA;
            end
            if (!prevP && PIXEL_CLK) begin
                if (haveFall) begin
                    checks++;
                    if ({LINE_VALID, FRAME_VALID, PIXEL_DATA} !== {fLv, fFv, fData}) begin
                        fails++;
                        $display("[TB] FAIL data_stable got lv=%b fv=%b d=%0d exp lv=%b fv=%b d=%0d",
                                 LINE_VALID, FRAME_VALID, PIXEL_DATA, fLv, fFv, fData);
                    end
                end
                if (LINE_VALID === 1'b1) begin
                    e = expQ.pop_front();
                    checks++; if (PIXEL_DATA !== e) begin fails++; $display("[TB] FAIL data_pixel got %0d exp %0d", PIXEL_DATA, e); end
                end else begin
                    checks++; if (PIXEL_DATA !== 10'd0) begin fails++; $display("[TB] FAIL data_blank got %0d exp 0", PIXEL_DATA); end
                end
            end
            prevP = PIXEL_CLK;
        end
        checks++; if (expQ.size() !== 0) begin fails++; $display("[TB] FAIL data_timeout got %0d left exp 0", expQ.size()); end
    endtask

    // Short Enable pulse: one frame only, then idle with FV low.
    task automatic test_single_frame();
        int cyc, fdSeen, fvHigh, busyHigh, fdExtra;
        doReset(1'b1);
        repeat (2) @(negedge Clk);
        Enable = 1'b0;
        cyc = 2; fdSeen = 0;
        while (fdSeen == 0 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            if (frame_done === 1'b1) fdSeen = 1;
        end
        checks++; if (fdSeen !== 1) begin fails++; $display("[TB] FAIL single_fd got none exp pulse"); end
        checks++; if (cyc !== 42) begin fails++; $display("[TB] FAIL single_fd_cycle got %0d exp 42", cyc); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL single_busy_end got %b exp 0", busy); end
        checks++; if (FRAME_VALID !== 1'b0) begin fails++; $display("[TB] FAIL single_fv_end got %b exp 0", FRAME_VALID); end
        fvHigh = 0; busyHigh = 0; fdExtra = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge Clk);
            if (FRAME_VALID !== 1'b0) fvHigh++;
            if (busy !== 1'b0) busyHigh++;
            if (frame_done !== 1'b0) fdExtra++;
        end
        checks++; if (fvHigh !== 0) begin fails++; $display("[TB] FAIL single_idle_fv got %0d exp 0", fvHigh); end
        checks++; if (busyHigh !== 0) begin fails++; $display("[TB] FAIL single_idle_busy got %0d exp 0", busyHigh); end
        checks++; if (fdExtra !== 0) begin fails++; $display("[TB] FAIL single_idle_fd got %0d exp 0", fdExtra); end
    endtask

    // Reset during the second active line, then restart from pixel 0.
    task automatic test_reset_mid_line();
        int         cyc, rises, fvRise;
        logic       prevLv, prevP;
        logic [9:0] e;
        doReset(1'b1);
        cyc = 0; rises = 0; prevLv = 1'b0;
        while (rises < 2 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            if (LINE_VALID === 1'b1 && !prevLv) rises++;
            prevLv = LINE_VALID;
        end
        repeat (2) @(negedge Clk);
        checks++; if (LINE_VALID !== 1'b1) begin fails++; $display("[TB] FAIL midline_lv got %b exp 1", LINE_VALID); end
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (PIXEL_CLK !== 1'b0) begin fails++; $display("[TB] FAIL midline_pclk got %b exp 0", PIXEL_CLK); end
        checks++; if (LINE_VALID !== 1'b0) begin fails++; $display("[TB] FAIL midline_lv0 got %b exp 0", LINE_VALID); end
        checks++; if (FRAME_VALID !== 1'b0) begin fails++; $display("[TB] FAIL midline_fv got %b exp 0", FRAME_VALID); end
        checks++; if (PIXEL_DATA !== 10'd0) begin fails++; $display("[TB] FAIL midline_data got %0d exp 0", PIXEL_DATA); end
        checks++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL midline_fd got %b exp 0", frame_done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midline_busy got %b exp 0", busy); end
        Reset = 1'b0;
        expQ.delete();
        for (int x = 0; x < H_ACTIVE; x++) expQ.push_back(expPix(x, 0, 0));
        cyc = 0; fvRise = -1; prevP = 1'b0;
        while (expQ.size() > 0 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            if (fvRise < 0 && FRAME_VALID === 1'b1) fvRise = cyc;
            if (!prevP && PIXEL_CLK && LINE_VALID === 1'b1) begin
                e = expQ.pop_front();
                checks++; if (PIXEL_DATA !== e) begin fails++; $display("[TB] FAIL midline_restart got %0d exp %0d", PIXEL_DATA, e); end
            end
            prevP = PIXEL_CLK;
        end
        checks++; if (fvRise !== CLK_DIV) begin fails++; $display("[TB] FAIL midline_fv_rise got %0d exp %0d", fvRise, CLK_DIV); end
        checks++; if (expQ.size() !== 0) begin fails++; $display("[TB] FAIL midline_timeout got %0d left exp 0", expQ.size()); end
    endtask

    // 1025 back-to-back frames: every pixel scoreboarded, frame counter wraps
    // so frame 1024 starts again at 0,1,2,3.
    task automatic test_back_to_back_wrap();
        int         cyc, frames, wrapPix;
        logic       prevP;
        logic [9:0] e;
        doReset(1'b1);
        expQ.delete();
        pushFrame(0);
        cyc = 0; frames = 0; prevP = 1'b0; wrapPix = 0;
        while (frames < 1025 && cyc < 1025 * 40 + 400) begin
            @(negedge Clk);
            cyc++;
            if (!prevP && PIXEL_CLK && LINE_VALID === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++; fails++;
                    $display("[TB] FAIL wrap_extra got %0d exp no pixel", PIXEL_DATA);
                end else begin
                    e = expQ.pop_front();
                    checks++; if (PIXEL_DATA !== e) begin fails++; $display("[TB] FAIL wrap_pixel frame %0d got %0d exp %0d", frames, PIXEL_DATA, e); end
                    if (frames == 1024 && wrapPix < H_ACTIVE) begin
                        checks++; if (PIXEL_DATA !== wrapPix[9:0]) begin fails++; $display("[TB] FAIL wrap_line0 got %0d exp %0d", PIXEL_DATA, wrapPix); end
                        wrapPix++;
                    end
                end
            end
            prevP = PIXEL_CLK;
            if (frame_done === 1'b1) begin
                frames++;
                if (frames < 1025) pushFrame(frames);
            end
        end
        checks++; if (frames !== 1025) begin fails++; $display("[TB] FAIL wrap_frames got %0d exp 1025", frames); end
        checks++; if (wrapPix !== H_ACTIVE) begin fails++; $display("[TB] FAIL wrap_line0_count got %0d exp %0d", wrapPix, H_ACTIVE); end
        checks++; if (expQ.size() !== 0) begin fails++; $display("[TB] FAIL wrap_leftover got %0d exp 0", expQ.size()); end
    endtask

    initial begin
        Reset  = 1'b1;
        Enable = 1'b0;
        $display("[TB] starting camera_pattern_gen bench");
        test_reset();
        test_frame_timing();
        test_pixel_data();
        test_single_frame();
        test_reset_mid_line();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/camera_pattern_gen.md
CAMERA_PATTERN_GEN -- requirements
Module: camera_pattern_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640: pixels per line.
- H_BLANK, 16: LINE_VALID-low pixel periods between lines.
- V_ACTIVE, 480: lines per frame.
- V_PRE, 2: pixel periods with FRAME_VALID high before the first line.
- V_POST, 2: pixel periods with FRAME_VALID high after the last line.
- V_BLANK, 8: pixel periods with FRAME_VALID low between frames.
- CLK_DIV, 2: Clk cycles per pixel period; even, at least 2.
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1: the single clock.
- Reset, in, 1: synchronous, active-high.
- Enable, in, 1: request frame generation.
- PIXEL_CLK, out, 1: emulated sensor pixel clock.
- LINE_VALID, out, 1: line qualifier.
- FRAME_VALID, out, 1: frame qualifier.
- PIXEL_DATA, out, 10: pixel value.
- frame_done, out, 1: one-Clk pulse at end of frame.
- busy, out, 1: high while a frame is in progress.
REQ-003 Clocking/reset: one clock Clk; Reset is synchronous, active-high.
REQ-004 All outputs registered; no combinational path from any input to any output.

Function
REQ-005 PIXEL_CLK toggles every CLK_DIV/2 Clk cycles, running continuously whenever Reset is low, including in IDLE.
REQ-006 Update rule: LINE_VALID, FRAME_VALID and PIXEL_DATA change only on the Clk edge where PIXEL_CLK goes 1->0 (the "fall tick"). They are therefore stable across every PIXEL_CLK rising edge, where the receiver samples.
REQ-007 States: IDLE, PRE, ACTIVE, HBLANK, POST, VBLANK. The state advances only on fall ticks; each fall tick is one pixel period.
REQ-008 IDLE:
- FV=0, LV=0, busy=0.
- Enable is sampled at fall ticks.
- Enable=1 -> PRE at that tick, with FV=1.
REQ-009 PRE: lasts V_PRE periods with FV=1, LV=0, then -> ACTIVE.
REQ-010 ACTIVE: lasts H_ACTIVE periods with LV=1 and x counting 0..H_ACTIVE-1.
- Not last line -> HBLANK.
- Last line -> POST.
REQ-011 HBLANK: lasts H_BLANK periods with LV=0, FV=1; y increments, then -> ACTIVE.
REQ-012 POST: lasts V_POST periods with FV=1, LV=0, then -> VBLANK with FV=0.
REQ-013 VBLANK: lasts V_BLANK periods with FV=0.
- frame_done pulses for one Clk on the tick that ends VBLANK.
- Enable=1 at that tick -> PRE (back-to-back frames).
- Enable=0 at that tick -> IDLE.
REQ-014 Enable deasserted mid-frame has no effect until the frame completes.
REQ-015 busy=1 in PRE, ACTIVE, HBLANK, POST and VBLANK.
REQ-016 PIXEL_DATA in ACTIVE = (x + y + frame_cnt) mod 1024, with 10-bit truncating addition. PIXEL_DATA=0 outside ACTIVE.
REQ-017 frame_cnt is 10 bits, increments on each frame_done, and wraps from 1023 to 0.
REQ-018 x and y reset to 0 at entry to PRE.
REQ-019 Frame length is V_PRE + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_POST + V_BLANK pixel periods.

Reset
REQ-020 Reset=1 at any Clk edge, including mid-line, forces the following on the next edge: state=IDLE, PIXEL_CLK=0, LV=0, FV=0, PIXEL_DATA=0, frame_done=0, busy=0, x=y=frame_cnt=0, divider=0.
REQ-021 After Reset falls, the first fall tick occurs CLK_DIV Clk cycles later.

Configuration
REQ-022 Macro CAM_FRAME_STAMP_EN controls frame stamping:
- Defined: the first ACTIVE pixel of each frame (x=0, y=0) outputs frame_cnt instead of the REQ-016 pattern.
- Undefined: every ACTIVE pixel follows REQ-016.
- All other behaviour is identical in both builds.

Verification
Bench parameters: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_PRE=1, V_POST=1, V_BLANK=2, CLK_DIV=2 (frame = 20 pixel periods = 40 Clk).
REQ-023 Enable held 1 from reset -> FV rises at the first fall tick; LV shows 3 pulses of 4 periods separated by 2; frame_done pulses 40 Clk after FV rises; the next FV rises at that same tick.
REQ-024 Frame 0 pixel data, undefined build -> line0 = 0,1,2,3; line1 = 1,2,3,4; line2 = 2,3,4,5. Frame 1, line0 = 1,2,3,4.
REQ-025 Enable pulsed 1 for 2 Clk, then 0 -> exactly one frame, then IDLE with busy=0; FV stays 0 for at least 100 Clk.
REQ-026 Reset asserted during the second ACTIVE line -> one Clk later all outputs are 0 and state is IDLE; after release with Enable=1, the frame restarts with data 0,1,2,3.
REQ-027 Run 1025 frames -> frame_cnt wraps to 0, and frame 1024 line0 = 0,1,2,3.
REQ-028 CAM_FRAME_STAMP_EN defined, frame 5 -> first pixel = 5; remaining pixels follow REQ-016 (second pixel = 6). Check at every PIXEL_CLK rising edge that LV, FV and DATA are unchanged since the previous fall tick.
